// File: rtl/riscv_core_scoreboard_pkg.sv
// Shared encodings for the dispatch-side register scoreboard.
package riscv_core_scoreboard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned ST_W  = 2;
    localparam int unsigned BYP_W = 2;
    localparam int unsigned CNT_W = 6;

    localparam logic [ST_W-1:0] SB_IDLE = 2'd0;
    localparam logic [ST_W-1:0] SB_PEND = 2'd1;
    localparam logic [ST_W-1:0] SB_DONE = 2'd2;

    localparam logic [BYP_W-1:0] BYP_RF  = 2'd0;
    localparam logic [BYP_W-1:0] BYP_WB  = 2'd1;
    localparam logic [BYP_W-1:0] BYP_ROB = 2'd2;

endpackage

// File: rtl/riscv_core_scoreboard_entry.sv
// One architectural register: producer state FSM and youngest producer slot.
module riscv_core_scoreboard_entry
    import riscv_core_scoreboard_pkg::*;
#(
    parameter int unsigned LOG_S = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue,
    input  logic [LOG_S-1:0] issue_slot,
    input  logic             wb_sel,
    input  logic [LOG_S-1:0] wb_slot,
    input  logic             commit_sel,
    input  logic [LOG_S-1:0] commit_slot,
    output logic [ST_W-1:0]  state,
    output logic [LOG_S-1:0] prod_slot,
    output logic             go_busy_c,
    output logic             go_idle_c
);

    logic [ST_W-1:0]  state_nxt;
    logic [LOG_S-1:0] prod_slot_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SB_IDLE;
            prod_slot <= '0;
        end else begin
            state     <= state_nxt;
            prod_slot <= prod_slot_nxt;
        end
    end

    // A new producer overrides any writeback or commit aimed at this register.
    always_comb begin
        state_nxt     = state;
        prod_slot_nxt = prod_slot;
        go_busy_c     = 1'b0;
        go_idle_c     = 1'b0;
        if (issue) begin
            state_nxt     = SB_PEND;
            prod_slot_nxt = issue_slot;
            go_busy_c     = (state == SB_IDLE);
        end else begin
            case (state)
                SB_PEND: begin
                    if (wb_sel && (wb_slot == prod_slot)) state_nxt = SB_DONE;
                end
                SB_DONE: begin
                    if (commit_sel && (commit_slot == prod_slot)) begin
                        state_nxt = SB_IDLE;
                        go_idle_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/riscv_core_scoreboard.sv
// Dispatch scoreboard: RAW stall, operand bypass select and ROB allocate handshake.
module riscv_core_scoreboard
    import riscv_core_scoreboard_pkg::*;
#(
    parameter int unsigned SLOTS = 16,
    parameter int unsigned LOG_S = 4,
    parameter int unsigned NREGS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dec_val,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_rs1_en,
    input  logic             dec_rs2_en,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_rd_en,
    output logic             dec_stall,
    output logic [BYP_W-1:0] src1_byp,
    output logic [BYP_W-1:0] src2_byp,
    output logic [LOG_S-1:0] src1_slot,
    output logic [LOG_S-1:0] src2_slot,
    output logic             rob_alloc_req_val,
    input  logic             rob_alloc_req_rdy,
    output logic [REG_W-1:0] rob_alloc_req_preg,
    input  logic [LOG_S-1:0] rob_alloc_resp_slot,
    output logic             issue_val,
    output logic [LOG_S-1:0] issue_slot,
    input  logic             wb_val,
    input  logic [LOG_S-1:0] wb_slot,
    input  logic             commit_wen,
    input  logic [LOG_S-1:0] commit_slot,
    input  logic [REG_W-1:0] commit_waddr,
    output logic [CNT_W-1:0] sb_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NREGS - 1);

    logic [ST_W-1:0]  reg_state [NREGS];
    logic [LOG_S-1:0] reg_prod  [NREGS];
    logic [NREGS-1:0] go_busy;
    logic [NREGS-1:0] go_idle;
    logic [REG_W-1:0] slot_rd   [SLOTS];
    logic [SLOTS-1:0] slot_v;

    logic                        raw_stall;
    logic                        fire;
    logic                        has_rd;
    logic                        wb_map_v;
    logic [REG_W-1:0]            wb_rd;
    logic [1:0][REG_W-1:0]       src_r;
    logic [1:0]                  src_en;
    logic [1:0][BYP_W-1:0]       src_byp;
    logic [1:0][LOG_S-1:0]       src_slot;
    logic [1:0]                  src_hz;

    assign reg_state[0] = SB_IDLE;
    assign reg_prod[0]  = '0;
    assign go_busy[0]   = 1'b0;
    assign go_idle[0]   = 1'b0;

    assign has_rd   = dec_rd_en && (dec_rd != '0);
    assign wb_map_v = wb_val && slot_v[wb_slot];
    assign wb_rd    = slot_rd[wb_slot];

    for (genvar i = 1; i < NREGS; i++) begin : g_ent
        riscv_core_scoreboard_entry #(.LOG_S(LOG_S)) u_entry (
            .clk         (clk),
            .reset_n     (reset_n),
            .issue       (fire && dec_rd_en && (dec_rd == REG_W'(i))),
            .issue_slot  (rob_alloc_resp_slot),
            .wb_sel      (wb_map_v && (wb_rd == REG_W'(i))),
            .wb_slot     (wb_slot),
            .commit_sel  (commit_wen && (commit_waddr == REG_W'(i))),
            .commit_slot (commit_slot),
            .state       (reg_state[i]),
            .prod_slot   (reg_prod[i]),
            .go_busy_c   (go_busy[i]),
            .go_idle_c   (go_idle[i])
        );
    end

    assign src_r  = {dec_rs2, dec_rs1};
    assign src_en = {dec_rs2_en, dec_rs1_en};

    // Operand source per read port; a pending producer only bypasses on its own writeback cycle.
    always_comb begin
        src_byp  = '0;
        src_slot = '0;
        src_hz   = '0;
        for (int s = 0; s < 2; s++) begin
            if (dec_val && src_en[s] && (src_r[s] != '0)) begin
                case (reg_state[src_r[s]])
                    SB_DONE: begin
                        src_byp[s]  = BYP_ROB;
                        src_slot[s] = reg_prod[src_r[s]];
                    end
                    SB_PEND: begin
                        if (wb_val && (wb_slot == reg_prod[src_r[s]])) begin
                            src_byp[s]  = BYP_WB;
                            src_slot[s] = reg_prod[src_r[s]];
                        end else begin
                            src_hz[s] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign raw_stall          = |src_hz;
    assign src1_byp           = src_byp[0];
    assign src2_byp           = src_byp[1];
    assign src1_slot          = src_slot[0];
    assign src2_slot          = src_slot[1];
    assign rob_alloc_req_val  = dec_val && !raw_stall;
    assign fire               = rob_alloc_req_val && rob_alloc_req_rdy;
    assign dec_stall          = dec_val && (raw_stall || !rob_alloc_req_rdy);
    assign issue_val          = fire;
    assign issue_slot         = dec_val ? rob_alloc_resp_slot : '0;
    assign rob_alloc_req_preg = (dec_val && dec_rd_en) ? dec_rd : '0;

    // Reverse map; an allocation into the slot being committed wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_v <= '0;
            for (int s = 0; s < SLOTS; s++) slot_rd[s] <= '0;
        end else begin
            if (commit_wen) slot_v[commit_slot] <= 1'b0;
            if (fire) begin
                slot_v[rob_alloc_resp_slot]  <= has_rd;
                slot_rd[rob_alloc_resp_slot] <= has_rd ? dec_rd : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_count <= '0;
        end else if ((|go_busy) && !(|go_idle) && (sb_count != CNT_MAX)) begin
            sb_count <= sb_count + CNT_W'(1);
        end else if ((|go_idle) && !(|go_busy) && (sb_count != '0)) begin
            sb_count <= sb_count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_core_scoreboard.sv
// Directed scoreboard bench: stimulus queues expected outputs, a negedge monitor compares.
module tb_riscv_core_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       dec_val;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_rs1_en, dec_rs2_en, dec_rd_en;
    logic       dec_stall;
    logic [1:0] src1_byp, src2_byp;
    logic [3:0] src1_slot, src2_slot;
    logic       rob_alloc_req_val, rob_alloc_req_rdy;
    logic [4:0] rob_alloc_req_preg;
    logic [3:0] rob_alloc_resp_slot;
    logic       issue_val;
    logic [3:0] issue_slot;
    logic       wb_val;
    logic [3:0] wb_slot;
    logic       commit_wen;
    logic [3:0] commit_slot;
    logic [4:0] commit_waddr;
    logic [5:0] sb_count;

    riscv_core_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .dec_val(dec_val),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
        .dec_rd(dec_rd), .dec_rd_en(dec_rd_en), .dec_stall(dec_stall),
        .src1_byp(src1_byp), .src2_byp(src2_byp), .src1_slot(src1_slot), .src2_slot(src2_slot),
        .rob_alloc_req_val(rob_alloc_req_val), .rob_alloc_req_rdy(rob_alloc_req_rdy),
        .rob_alloc_req_preg(rob_alloc_req_preg), .rob_alloc_resp_slot(rob_alloc_resp_slot),
        .issue_val(issue_val), .issue_slot(issue_slot), .wb_val(wb_val), .wb_slot(wb_slot),
        .commit_wen(commit_wen), .commit_slot(commit_slot), .commit_waddr(commit_waddr),
        .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic       rv;
        logic       iv;
        logic [3:0] islot;
        logic [1:0] b1;
        logic [3:0] s1;
        logic [1:0] b2;
        logic [3:0] s2;
        logic [4:0] preg;
        logic [5:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    exp_t  e;
    string nm;
    logic  bad;

    // Monitor: one queued expectation is checked per negedge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            bad = (dec_stall !== e.stall) || (rob_alloc_req_val !== e.rv) || (issue_val !== e.iv)
               || (e.iv && (issue_slot !== e.islot))
               || (src1_byp !== e.b1) || ((e.b1 != 2'd0) && (src1_slot !== e.s1))
               || (src2_byp !== e.b2) || ((e.b2 != 2'd0) && (src2_slot !== e.s2))
               || (rob_alloc_req_preg !== e.preg) || (sb_count !== e.cnt);
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL %s: got stall=%0b rv=%0b iv=%0b islot=%0d b1=%0d s1=%0d b2=%0d s2=%0d preg=%0d cnt=%0d | want stall=%0b rv=%0b iv=%0b islot=%0d b1=%0d s1=%0d b2=%0d s2=%0d preg=%0d cnt=%0d",
                         nm, dec_stall, rob_alloc_req_val, issue_val, issue_slot, src1_byp, src1_slot,
                         src2_byp, src2_slot, rob_alloc_req_preg, sb_count,
                         e.stall, e.rv, e.iv, e.islot, e.b1, e.s1, e.b2, e.s2, e.preg, e.cnt);
            end
        end
    end

    task automatic idle();
        dec_val = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_en = 0; dec_rs2_en = 0;
        dec_rd = 0; dec_rd_en = 0; rob_alloc_req_rdy = 0; rob_alloc_resp_slot = 0;
        wb_val = 0; wb_slot = 0; commit_wen = 0; commit_slot = 0; commit_waddr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk(input string name, input logic stall, input logic rv, input logic iv,
                       input logic [3:0] islot, input logic [1:0] b1, input logic [3:0] s1,
                       input logic [1:0] b2, input logic [3:0] s2, input logic [4:0] preg,
                       input logic [5:0] cnt);
        exp_t x;
        x = '{stall: stall, rv: rv, iv: iv, islot: islot, b1: b1, s1: s1, b2: b2, s2: s2,
              preg: preg, cnt: cnt};
        exp_q.push_back(x);
        name_q.push_back(name);
    endtask

    task automatic dec(input logic [4:0] rs1, input logic rs1_en, input logic [4:0] rs2,
                       input logic rs2_en, input logic [4:0] rd, input logic rd_en,
                       input logic rdy, input logic [3:0] slot);
        dec_val = 1; dec_rs1 = rs1; dec_rs1_en = rs1_en; dec_rs2 = rs2; dec_rs2_en = rs2_en;
        dec_rd = rd; dec_rd_en = rd_en; rob_alloc_req_rdy = rdy; rob_alloc_resp_slot = slot;
    endtask

    task automatic wb(input logic [3:0] s);
        wb_val = 1; wb_slot = s;
    endtask

    task automatic cmt(input logic [3:0] s, input logic [4:0] r);
        commit_wen = 1; commit_slot = s; commit_waddr = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        reset_n = 0;
        idle();
        @(posedge clk); #1;
        chk("reset", 0,0,0,0, 0,0,0,0, 0, 0); tick();
        reset_n = 1;

        // 1: RAW stall on x5 until its writeback, then WB bypass
        dec(1,1, 0,0, 5,1, 1, 0);  chk("t1_add",       0,1,1,0, 0,0,0,0, 5, 0); tick();
        dec(5,1, 0,0, 6,1, 1, 1);  chk("t1_sub_stall", 1,0,0,0, 0,0,0,0, 6, 1); tick();
        dec(5,1, 0,0, 6,1, 1, 1); wb(0);
                                   chk("t1_sub_wbbyp", 0,1,1,1, 1,0,0,0, 6, 1); tick();
        // 2: x5 DONE in slot 3 -> ROB bypass; commit frees it
        dec(0,0, 0,0, 5,1, 1, 3);  chk("t2_reissue",   0,1,1,3, 0,0,0,0, 5, 2); tick();
        wb(3);                     chk("t2_wb_only",   0,0,0,0, 0,0,0,0, 0, 2); tick();
        dec(5,1, 0,0, 0,0, 1, 5);  chk("t2_rob_byp",   0,1,1,5, 2,3,0,0, 0, 2); tick();
        cmt(3, 5); wb(1);          chk("t2_cmt_wb",    0,0,0,0, 0,0,0,0, 0, 2); tick();
        dec(0,0, 5,1, 0,0, 1, 6); cmt(1, 6);
                                   chk("t2_after_cmt", 0,1,1,6, 0,0,0,0, 0, 1); tick();
        // 3: WAW on x7, stale writeback/commit from slot 1 ignored
        dec(0,0, 0,0, 7,1, 1, 1);  chk("t3_x7a",       0,1,1,1, 0,0,0,0, 7, 0); tick();
        dec(0,0, 0,0, 7,1, 1, 2);  chk("t3_x7b",       0,1,1,2, 0,0,0,0, 7, 1); tick();
        dec(7,1, 0,0, 0,0, 0, 0); wb(1);
                                   chk("t3_stale_wb",  1,0,0,0, 0,0,0,0, 0, 1); tick();
        dec(7,1, 0,0, 0,0, 1, 0); cmt(1, 7);
                                   chk("t3_pend_cmt",  1,0,0,0, 0,0,0,0, 0, 1); tick();
        dec(7,1, 0,0, 0,0, 1, 0);  chk("t3_still_pend",1,0,0,0, 0,0,0,0, 0, 1); tick();
        dec(0,0, 7,1, 0,0, 1, 7); wb(2);
                                   chk("t3_wb_new",    0,1,1,7, 0,0,1,2, 0, 1); tick();
        dec(7,1, 0,0, 0,0, 1, 8);  chk("t3_done",      0,1,1,8, 2,2,0,0, 0, 1); tick();
        // 4: ROB not ready
        dec(7,1, 0,0, 8,1, 0, 9);  chk("t4_not_rdy",   1,1,0,0, 2,2,0,0, 8, 1); tick();
        dec(8,1, 0,0, 0,0, 1, 10); chk("t4_no_change", 0,1,1,10,0,0,0,0, 0, 1); tick();
        // 5: issue and commit of x9 in the same cycle
        cmt(2, 7);                 chk("t5_free_x7",   0,0,0,0, 0,0,0,0, 0, 1); tick();
        dec(0,0, 0,0, 9,1, 1, 2);  chk("t5_x9_s2",     0,1,1,2, 0,0,0,0, 9, 0); tick();
        wb(2);                     chk("t5_wb_s2",     0,0,0,0, 0,0,0,0, 0, 1); tick();
        dec(0,0, 0,0, 9,1, 1, 4); cmt(2, 9);
                                   chk("t5_iss_cmt",   0,1,1,4, 0,0,0,0, 9, 1); tick();
        dec(9,1, 0,0, 0,0, 0, 0); wb(4);
                                   chk("t5_pend_s4",   1,1,0,0, 1,4,0,0, 0, 1); tick();
        cmt(4, 9);                 chk("t5_cmt_s4",    0,0,0,0, 0,0,0,0, 0, 1); tick();
        // 6: fill ten registers, then asynchronous reset
        for (int i = 0; i < 10; i++) begin
            dec(0,0, 0,0, 5'(10 + i),1, 1, 4'(i));
            chk("t6_fill", 0,1,1,4'(i), 0,0,0,0, 5'(10 + i), 6'(i));
            tick();
        end
        dec(12,1, 0,1, 0,0, 1, 11); chk("t6_full",     1,0,0,0, 0,0,0,0, 0, 10); tick();
        reset_n = 0;                chk("t6_reset",    0,0,0,0, 0,0,0,0, 0, 0); tick();
        reset_n = 1;
        dec(12,1, 0,1, 0,0, 1, 12); chk("t6_post_rst", 0,1,1,12,0,0,0,0, 0, 0); tick();
        dec(0,1, 0,0, 0,1, 1, 3);   chk("t6_x0_dest",  0,1,1,3, 0,0,0,0, 0, 0); tick();
        dec(0,1, 0,1, 0,0, 1, 4);   chk("t6_x0_read",  0,1,1,4, 0,0,0,0, 0, 0); tick();

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
